// File: rtl/atsc_dc_blocker.sv
// Streaming DC blocker: subtracts the running mean of the last 2^LOG2_LEN samples from I and Q.
// Define DCB_SAT_EN to saturate the difference to 16 bits; otherwise it wraps.
module atsc_dc_blocker #(
    parameter int LOG2_LEN = 6,
    parameter int SR_CTRL  = 132
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] in_tdata,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready
);
    localparam int N  = 1 << LOG2_LEN;
    localparam int SW = 16 + LOG2_LEN;
    localparam int FW = LOG2_LEN + 1;
    localparam logic [7:0] CTRL_ADDR = 8'(SR_CTRL);

    logic                    out_tvalid_q, out_tvalid_d;
    logic [31:0]             out_tdata_q, out_tdata_d;
    logic                    out_tlast_q, out_tlast_d;
    logic signed [SW-1:0]    sum_i_q, sum_i_d, sum_q_q, sum_q_d;
    logic [FW-1:0]           fill_q, fill_d;
    logic [LOG2_LEN-1:0]     ptr_q, ptr_d;
    logic                    bypass_q, bypass_d;
    logic                    clear_q, clear_d;

    logic [31:0]             win_mem [N];

    logic                    accept, ctrl_wr;
    logic signed [SW-1:0]    sum_i_eff, sum_q_eff, mean_i, mean_q;
    logic [FW-1:0]           fill_eff;
    logic [LOG2_LEN-1:0]     ptr_eff;
    logic [31:0]             oldest;
    logic signed [15:0]      x_i, x_q, old_i, old_q;
    logic [16:0]             diff_i, diff_q;
    logic [15:0]             res_i, res_q;
    logic                    unused_bits;

    assign in_tready  = ~out_tvalid_q | out_tready;
    assign accept     = in_tvalid & in_tready;
    assign ctrl_wr    = set_stb & (set_addr == CTRL_ADDR);
    assign out_tdata  = out_tdata_q;
    assign out_tlast  = out_tlast_q;
    assign out_tvalid = out_tvalid_q;

    // A pending clear makes this cycle's sample start a fresh window.
    assign sum_i_eff = clear_q ? '0 : sum_i_q;
    assign sum_q_eff = clear_q ? '0 : sum_q_q;
    assign fill_eff  = clear_q ? '0 : fill_q;
    assign ptr_eff   = clear_q ? '0 : ptr_q;

    assign oldest = (fill_eff == FW'(N)) ? win_mem[ptr_eff] : '0;
    assign x_i    = in_tdata[31:16];
    assign x_q    = in_tdata[15:0];
    assign old_i  = oldest[31:16];
    assign old_q  = oldest[15:0];
    assign mean_i = sum_i_eff >>> LOG2_LEN;
    assign mean_q = sum_q_eff >>> LOG2_LEN;
    assign diff_i = 17'(x_i) - mean_i[16:0];
    assign diff_q = 17'(x_q) - mean_q[16:0];

`ifdef DCB_SAT_EN
    assign res_i = (diff_i[16] != diff_i[15]) ? (diff_i[16] ? 16'h8000 : 16'h7fff) : diff_i[15:0];
    assign res_q = (diff_q[16] != diff_q[15]) ? (diff_q[16] ? 16'h8000 : 16'h7fff) : diff_q[15:0];
`else
    assign res_i = diff_i[15:0];
    assign res_q = diff_q[15:0];
`endif

    assign unused_bits = ^{set_data[31:2], mean_i[SW-1:17], mean_q[SW-1:17], diff_i[16], diff_q[16]};

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        sum_i_d      = sum_i_eff;
        sum_q_d      = sum_q_eff;
        fill_d       = fill_eff;
        ptr_d        = ptr_eff;
        bypass_d     = ctrl_wr ? set_data[0] : bypass_q;
        clear_d      = ctrl_wr & set_data[1];

        if (accept) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = bypass_q ? in_tdata : {res_i, res_q};
            out_tlast_d  = in_tlast;
            sum_i_d      = sum_i_eff + SW'(x_i) - SW'(old_i);
            sum_q_d      = sum_q_eff + SW'(x_q) - SW'(old_q);
            ptr_d        = ptr_eff + LOG2_LEN'(1);
            if (fill_eff != FW'(N)) begin
                fill_d = fill_eff + FW'(1);
            end
        end else if (out_tready) begin
            out_tvalid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tlast_q  <= 1'b0;
            sum_i_q      <= '0;
            sum_q_q      <= '0;
            fill_q       <= '0;
            ptr_q        <= '0;
            bypass_q     <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
            sum_i_q      <= sum_i_d;
            sum_q_q      <= sum_q_d;
            fill_q       <= fill_d;
            ptr_q        <= ptr_d;
            bypass_q     <= bypass_d;
            clear_q      <= clear_d;
        end
    end

    // NOTE: the window RAM is not reset; the fill counter masks entries not yet written.
    always_ff @(posedge ce_clk) begin
        if (accept) begin
            win_mem[ptr_eff] <= in_tdata;
        end
    end

endmodule

// File: tb/tb_atsc_dc_blocker.sv
// Directed self-checking bench for atsc_dc_blocker with an averaging window of 16 samples.
module tb_atsc_dc_blocker;
    localparam int L = 4;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] in_tdata;
    logic        in_tlast, in_tvalid, in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast, out_tvalid, out_tready;

    int n_checks = 0;
    int n_errors = 0;

    atsc_dc_blocker #(.LOG2_LEN(L), .SR_CTRL(132)) dut (
        .ce_clk    (ce_clk),
        .ce_rst    (ce_rst),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .in_tdata  (in_tdata),
        .in_tlast  (in_tlast),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .out_tdata (out_tdata),
        .out_tlast (out_tlast),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready)
    );

    initial forever #5 ce_clk = ~ce_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] q, input logic last);
        @(negedge ce_clk);
        in_tdata  = {i, q};
        in_tlast  = last;
        in_tvalid = 1'b1;
        @(posedge ce_clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic write_ctrl(input logic [7:0] addr, input logic [31:0] data);
        @(negedge ce_clk);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        @(posedge ce_clk);
        #1;
        set_stb = 1'b0;
    endtask

    initial begin
        int exp_i, exp_q, k, m, cyc;
        logic fire_in;

        ce_rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
        in_tdata = '0; in_tlast = 1'b0; in_tvalid = 1'b0; out_tready = 1'b1;
        repeat (2) @(posedge ce_clk);
        @(negedge ce_clk);
        ce_rst = 1'b0;

        check("rst_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_tdata", out_tdata, 32'd0);
        check("rst_tlast", 32'(out_tlast), 32'd0);
        check("rst_tready", 32'(in_tready), 32'd1);

        // Constant I=1000 / Q=-500: mean ramps up over 16 samples.
        for (int n = 0; n < 20; n++) begin
            push(16'd1000, 16'hFE0C, 1'b0);
            exp_i = (n < 16) ? 1000 - (n * 1000) / 16 : 0;
            exp_q = (n < 16) ? -500 + (n * 500 + 15) / 16 : 0;
            check($sformatf("const_n%0d", n), out_tdata, {16'(exp_i), 16'(exp_q)});
            if (n == 0) check("const_tvalid", 32'(out_tvalid), 32'd1);
        end

        // Settle on I=2000, then clear and watch the ramp restart.
        for (int n = 0; n < 40; n++) push(16'd2000, 16'd0, 1'b0);
        check("pre_clear", out_tdata, 32'd0);
        write_ctrl(8'd132, 32'h2);
        push(16'd2000, 16'd0, 1'b0);
        check("clear_n0", out_tdata, {16'd2000, 16'd0});
        push(16'd2000, 16'd0, 1'b0);
        check("clear_n1", out_tdata, {16'd1875, 16'd0});
        push(16'd2000, 16'd0, 1'b0);
        check("clear_n2", out_tdata, {16'd1750, 16'd0});

        // Full-scale step: 16 x -32768 then +32767.
        write_ctrl(8'd132, 32'h2);
        for (int n = 0; n < 16; n++) begin
            push(16'h8000, 16'd0, 1'b0);
            if (n == 0) check("step_n0", out_tdata, {16'h8000, 16'd0});
        end
        push(16'h7FFF, 16'd0, 1'b0);
`ifdef DCB_SAT_EN
        check("step_sat", out_tdata, {16'h7FFF, 16'd0});
`else
        check("step_wrap", out_tdata, {16'hFFFF, 16'd0});
`endif

        // Bypass keeps the window updating; foreign address writes are ignored.
        write_ctrl(8'd132, 32'h2);
        write_ctrl(8'd132, 32'h1);
        for (int n = 0; n < 4; n++) begin
            push(16'd123, 16'hFFF9, 1'b0);
            check($sformatf("bypass_n%0d", n), out_tdata, {16'd123, 16'hFFF9});
        end
        write_ctrl(8'd132, 32'h0);
        push(16'd123, 16'hFFF9, 1'b0);
        check("unbypass_n4", out_tdata, {16'd93, 16'hFFFB});
        write_ctrl(8'd131, 32'h3);
        push(16'd123, 16'hFFF9, 1'b0);
        check("other_addr_n5", out_tdata, {16'd85, 16'hFFFC});

        // Backpressure: out_tready low for 5 cycles while a packet streams in.
        write_ctrl(8'd132, 32'h2);
        k = 0; m = 0; cyc = 0;
        while (m < 6 && cyc < 40) begin
            @(negedge ce_clk);
            in_tvalid  = (k < 6);
            in_tdata   = {16'(16 * (k + 1)), 16'(k)};
            in_tlast   = (k == 5);
            out_tready = !(cyc >= 2 && cyc <= 6);
            #1;
            if (out_tvalid && out_tready) begin
                check($sformatf("bp_data_m%0d", m), out_tdata,
                      {16'(16 * (m + 1) - m * (m + 1) / 2), 16'(m)});
                check($sformatf("bp_last_m%0d", m), 32'(out_tlast), 32'(m == 5));
                m++;
            end else if (out_tvalid && !out_tready) begin
                check($sformatf("bp_stall_ready_c%0d", cyc), 32'(in_tready), 32'd0);
                check($sformatf("bp_stall_data_c%0d", cyc), out_tdata,
                      {16'(16 * (m + 1) - m * (m + 1) / 2), 16'(m)});
            end
            fire_in = in_tvalid && in_tready;
            @(posedge ce_clk);
            if (fire_in) k++;
            cyc++;
        end
        in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b1;
        check("bp_outputs_seen", 32'(m), 32'd6);
        check("bp_inputs_taken", 32'(k), 32'd6);

        // Asynchronous reset while a sample is held.
        for (int n = 0; n < 3; n++) push(16'd500, 16'hFED4, 1'b0);
        @(negedge ce_clk);
        out_tready = 1'b0;
        in_tdata   = {16'd500, 16'hFED4};
        in_tvalid  = 1'b1;
        @(posedge ce_clk);
        #1;
        in_tvalid = 1'b0;
        check("hold_tvalid", 32'(out_tvalid), 32'd1);
        #2;
        ce_rst = 1'b1;
        #1;
        check("async_rst_tvalid", 32'(out_tvalid), 32'd0);
        check("async_rst_tdata", out_tdata, 32'd0);
        @(negedge ce_clk);
        ce_rst = 1'b0;
        out_tready = 1'b1;
        push(16'd500, 16'hFED4, 1'b0);
        check("post_rst_raw", out_tdata, {16'd500, 16'hFED4});
        check("post_rst_tvalid", 32'(out_tvalid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/atsc_dc_blocker.md
Name: atsc_dc_blocker

Overview:
- Streaming DC-removal stage sitting directly upstream of the AGC in the ATSC RX chain, on the ce_clk side of the axi_wrapper.
- Input is sc16 samples: I in [31:16], Q in [15:0].
- For each of I and Q it subtracts a running mean over the previous 2^LOG2_LEN accepted samples, so the AGC sees a zero-mean signal.
- Control comes from the noc_shell settings bus; the address range is chosen not to collide with the AGC registers 128-131.

Parameters:
LOG2_LEN, 6, log2 of averaging window length N (N = 2^LOG2_LEN; legal 2..10)
SR_CTRL, 132, settings-bus address of the control register

Ports:
ce_clk  input  1  block clock
ce_rst  input  1  asynchronous active-high reset
set_stb  input  1  settings-bus write strobe
set_addr  input  8  settings-bus address
set_data  input  32  settings-bus data
in_tdata  input  32  input sample, I [31:16], Q [15:0], two's complement
in_tlast  input  1  end of packet
in_tvalid  input  1  input valid
in_tready  output  1  input ready
out_tdata  output  32  DC-removed sample, same packing
out_tlast  output  1  end of packet, passed through with its sample
out_tvalid  output  1  output valid
out_tready  input  1  downstream ready

Behaviour:
- Single clock ce_clk; ce_rst asynchronous, active-high.
- Reset state:
  - out_tvalid=0, out_tdata=0, out_tlast=0.
  - Running sums=0, fill counter=0, write pointer=0, ctrl register=0.
- Handshake:
  - in_tready = ~out_tvalid | out_tready.
  - A sample is accepted when in_tvalid & in_tready.
  - Output register loads on the cycle of acceptance; latency is 1 cycle; throughput is 1 sample per cycle.
  - out_tvalid holds, with tdata and tlast stable, until out_tready.
- Arithmetic, per component, for accepted sample index n since the last reset/clear:
  - S[n-1] = sum of x[n-N .. n-1], with x[k]=0 for k<0.
  - Window storage is a circular buffer of N entries (RAM allowed). Entries not yet written since reset/clear read as 0, gated by a fill counter that saturates at N.
  - Sum width is 16+LOG2_LEN bits, signed; S is updated as S + x[n] - x[n-N] on acceptance.
  - mean = S[n-1] >>> LOG2_LEN (arithmetic shift, floor).
  - diff = x[n] - mean, computed at 17 bits.
  - The 17-bit diff is reduced to 16 bits as selected by DCB_SAT_EN.
- Control register at SR_CTRL, written when set_stb & set_addr==SR_CTRL:
  - bit0 bypass (level): out_tdata = in_tdata unchanged; sums and window still update.
  - bit1 clear (self-clearing pulse): next cycle, sums=0, fill=0, pointer=0.
  - A sample accepted in the same cycle clear takes effect is treated as n=0 of the new window (mean 0).
  - Clear does not touch a sample already held in the output register.
- Other addresses are ignored.
- Reset asserted mid-stream: all state returns to reset values immediately, and any held output is discarded.

Optional Feature:
- Macro DCB_SAT_EN.
- Defined: the 17-bit diff saturates to [-32768, 32767].
- Undefined: the 17-bit diff is truncated to its low 16 bits (wrap).

Test Plan:
- LOG2_LEN=4, constant I=1000/Q=-500 stream:
  - I outputs are 1000, 938, 875 ... (1000 - floor(n*1000/16)), reaching 0 at n=16 and staying 0.
  - Q at n=1 is -468.
- 16 samples of I=-32768, then I=+32767 (LOG2_LEN=4):
  - The 17th output I is 32767 with DCB_SAT_EN.
  - Without DCB_SAT_EN it is -1 (0xFFFF).
- Hold out_tready=0 for 5 cycles mid-packet with in_tvalid=1:
  - in_tready=0 while one sample is held.
  - No sample is lost or duplicated; tlast stays aligned with its sample.
- Constant I=2000 for 40 samples, then write SR_CTRL=0x2, then continue:
  - The first post-clear output is I=2000.
  - Ramp-down restarts: 1875 at the next sample.
- Write SR_CTRL=0x1 and feed I=123/Q=-7:
  - Output is identical to the input.
  - After SR_CTRL=0x0 the output resumes the correct DC-removed values, because the window kept updating.
- Assert ce_rst asynchronously between clock edges while out_tvalid=1:
  - out_tvalid=0 immediately.
  - After release, the first output equals the raw input (mean 0).
